// File: rtl/hdmi_period_scheduler.sv
// HDMI period scheduler: raster counters, syncs and the control/preamble/guard/active period sequence.
// Define HDMI_SCHED_GUARD_EN for HDMI mode (preamble + guard band); undefined gives DVI mode.
module hdmi_period_scheduler #(
  parameter int HA           = 640,
  parameter int HF           = 16,
  parameter int HS           = 96,
  parameter int HB           = 48,
  parameter int VA           = 480,
  parameter int VF           = 10,
  parameter int VS           = 2,
  parameter int VB           = 33,
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  localparam int HTOTAL      = HA + HF + HS + HB,
  localparam int VTOTAL      = VA + VF + VS + VB,
  localparam int HW          = $clog2(HTOTAL),
  localparam int VW          = $clog2(VTOTAL)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_cfg_valid,
  input  logic [31:0]   i_cfg_data,
  output logic [HW-1:0] o_hcount,
  output logic [VW-1:0] o_vcount,
  output logic          o_frame_start,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_data_en,
  output logic          o_guard_en,
  output logic [3:0]    o_ctl,
  output logic          o_tp_sel
);

  localparam logic [HW-1:0] H_LAST    = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(HA);
  localparam logic [HW-1:0] HS_BEG    = HW'(HA + HF);
  localparam logic [HW-1:0] HS_END    = HW'(HA + HF + HS);
  localparam logic [HW-1:0] PRE_BEG   = HW'(HTOTAL - PREAMBLE_LEN - GUARD_LEN);
  localparam logic [HW-1:0] GRD_BEG   = HW'(HTOTAL - GUARD_LEN);
  localparam logic [VW-1:0] V_LAST    = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(VA);
  localparam logic [VW-1:0] V_ACT_LST = VW'(VA - 1);
  localparam logic [VW-1:0] VS_BEG    = VW'(VA + VF);
  localparam logic [VW-1:0] VS_END    = VW'(VA + VF + VS);

  typedef struct packed {
    logic tp_sel;
    logic vpol;
    logic hpol;
    logic enable;
  } cfg_t;

  localparam cfg_t CFG_RESET = cfg_t'(4'b1001);

  // State bits map straight onto the outputs: [0] CTL0, [1] guard band, [2] data enable.
  typedef enum logic [2:0] {
    CTRL     = 3'b000,
    PREAMBLE = 3'b001,
    GUARD    = 3'b010,
    ACTIVE   = 3'b100
  } state_t;

  logic [HW-1:0] hcount_r;
  logic [VW-1:0] vcount_r;
  logic          frame_start_r;
  logic          hsync_r;
  logic          vsync_r;
  cfg_t          pending_r;
  cfg_t          committed_r;
  state_t        state_r;
  state_t        next_state;

  logic h_wrap;
  logic v_wrap;
  logic frame_wrap;
  logic hs_raw;
  logic vs_raw;
  logic next_active;
  logic in_active;
  logic in_pre;
  logic in_guard;
  logic unused_cfg_bits;

  assign unused_cfg_bits = ^i_cfg_data[31:4];

  assign h_wrap     = (hcount_r == H_LAST);
  assign v_wrap     = (vcount_r == V_LAST);
  assign frame_wrap = h_wrap && v_wrap;

  assign hs_raw      = (hcount_r >= HS_BEG) && (hcount_r < HS_END);
  assign vs_raw      = (vcount_r >= VS_BEG) && (vcount_r < VS_END);
  assign next_active = (vcount_r < V_ACT_LST) || v_wrap;
  assign in_active   = committed_r.enable && (hcount_r < H_ACT_END) && (vcount_r < V_ACT_END);

`ifdef HDMI_SCHED_GUARD_EN
  assign in_pre   = committed_r.enable && next_active && (hcount_r >= PRE_BEG) && (hcount_r < GRD_BEG);
  assign in_guard = committed_r.enable && next_active && (hcount_r >= GRD_BEG);
`else
  assign in_pre   = 1'b0;
  assign in_guard = 1'b0;
`endif

  // Raster counters and the frame-start pulse aligned with counters at (0,0).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcount_r      <= '0;
      vcount_r      <= '0;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= frame_wrap;
      if (h_wrap) begin
        hcount_r <= '0;
        vcount_r <= v_wrap ? '0 : vcount_r + VW'(1);
      end else begin
        hcount_r <= hcount_r + HW'(1);
      end
    end
  end

  // Config shadow: writes land in pending; pending commits only on the frame wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_r   <= CFG_RESET;
      committed_r <= CFG_RESET;
    end else begin
      if (frame_wrap) begin
        committed_r <= pending_r;
      end
      if (i_cfg_valid) begin
        pending_r <= cfg_t'(i_cfg_data[3:0]);
      end
    end
  end

  // Polarity-adjusted syncs, produced regardless of enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
    end else begin
      hsync_r <= committed_r.hpol ? hs_raw : ~hs_raw;
      vsync_r <= committed_r.vpol ? vs_raw : ~vs_raw;
    end
  end

  // Period decode from the current counters.
  always_comb begin
    next_state = CTRL;
    if (in_active) begin
      next_state = ACTIVE;
    end else if (in_guard) begin
      next_state = GUARD;
    end else if (in_pre) begin
      next_state = PREAMBLE;
    end else begin
      next_state = CTRL;
    end
  end

  // Period state register; its bits are the registered period outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= CTRL;
    end else begin
      state_r <= next_state;
    end
  end

  assign o_hcount      = hcount_r;
  assign o_vcount      = vcount_r;
  assign o_frame_start = frame_start_r;
  assign o_hsync       = hsync_r;
  assign o_vsync       = vsync_r;
  assign o_data_en     = state_r[2];
  assign o_guard_en    = state_r[1];
  assign o_ctl         = {3'b000, state_r[0]};
  assign o_tp_sel      = committed_r.tp_sel;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Randomized self-checking bench for hdmi_period_scheduler against a per-pixel behavioural model.
// Uses a reduced raster so many frames fit in a short run.
module tb_hdmi_period_scheduler;

  localparam int HA = 16, HF = 4, HS = 6, HB = 14;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int PRE = 8, GRD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
`ifdef HDMI_SCHED_GUARD_EN
  localparam bit HDMI = 1'b1;
`else
  localparam bit HDMI = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [31:0]   cfg_data = 32'd0;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          frame_start, hsync, vsync, data_en, guard_en, tp_sel;
  logic [3:0]    ctl;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_fs = 0;

  // model state: counters, committed/pending config, expected registered outputs
  int       mh, mv;
  logic [3:0] c_cfg, p_cfg;
  logic     e_de, e_ge, e_fs, e_hs, e_vs;
  logic [3:0] e_ctl;

  always #5 clk = ~clk;

  hdmi_period_scheduler #(
    .HA(HA), .HF(HF), .HS(HS), .HB(HB), .VA(VA), .VF(VF), .VS(VS), .VB(VB),
    .PREAMBLE_LEN(PRE), .GUARD_LEN(GRD)
  ) dut (
    .clk(clk), .rstn(rstn), .i_cfg_valid(cfg_valid), .i_cfg_data(cfg_data),
    .o_hcount(hcount), .o_vcount(vcount), .o_frame_start(frame_start),
    .o_hsync(hsync), .o_vsync(vsync), .o_data_en(data_en), .o_guard_en(guard_en),
    .o_ctl(ctl), .o_tp_sel(tp_sel)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t (h=%0d v=%0d): got %0h expected %0h", tag, $time, mh, mv, obs, exp);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0;
    c_cfg = 4'b1001; p_cfg = 4'b1001;
    e_de = 1'b0; e_ge = 1'b0; e_ctl = 4'd0; e_fs = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
  endtask

  // One pixel clock: outputs describe the pixel just left, then config and position advance.
  task automatic model_step(input bit v, input logic [31:0] d);
    bit en, next_act, hs, vs;
    int left;
    en       = c_cfg[0];
    left     = HT - mh;
    next_act = ((mv + 1) % VT) < VA;
    hs       = (mh >= HA + HF) && (mh < HA + HF + HS);
    vs       = (mv >= VA + VF) && (mv < VA + VF + VS);
    e_hs  = c_cfg[1] ? hs : !hs;
    e_vs  = c_cfg[2] ? vs : !vs;
    e_de  = en && (mh < HA) && (mv < VA);
    e_ge  = HDMI && en && next_act && (left <= GRD);
    e_ctl = (HDMI && en && next_act && left > GRD && left <= GRD + PRE) ? 4'b0001 : 4'b0000;
    e_fs  = (mh == HT - 1) && (mv == VT - 1);
    if (e_fs) c_cfg = p_cfg;
    if (v) p_cfg = d[3:0];
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv + 1) % VT;
    end
  endtask

  task automatic compare_all();
    check_eq("hcount", 32'(hcount), 32'(mh));
    check_eq("vcount", 32'(vcount), 32'(mv));
    check_eq("frame_start", 32'(frame_start), 32'(e_fs));
    check_eq("hsync", 32'(hsync), 32'(e_hs));
    check_eq("vsync", 32'(vsync), 32'(e_vs));
    check_eq("data_en", 32'(data_en), 32'(e_de));
    check_eq("guard_en", 32'(guard_en), 32'(e_ge));
    check_eq("ctl", 32'(ctl), 32'(e_ctl));
    check_eq("tp_sel", 32'(tp_sel), 32'(c_cfg[3]));
  endtask

  task automatic cycle(input bit v, input logic [31:0] d);
    cfg_valid = v;
    cfg_data  = d;
    @(posedge clk);
    cyc++;
    model_step(v, d);
    @(negedge clk);
    compare_all();
    if (frame_start) begin
      check_eq("frame_period", 32'(cyc - last_fs), 32'(FT));
      last_fs = cyc;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom);
  endtask

  task automatic goto_wrap();
    for (int i = 0; i < FT && !(mh == HT - 1 && mv == VT - 1); i++) cycle(1'b0, $urandom);
    check_eq("reach_wrap", 32'((mh == HT - 1) && (mv == VT - 1)), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rstn = 1'b1;
    cyc = 0; last_fs = 0;

    // default configuration over two frames
    idle(2 * FT);
    // polarity flip written mid-frame
    idle(FT / 2);
    cycle(1'b1, 32'h0000_0006);
    idle(2 * FT);
    // two writes in one frame: last wins
    idle(FT / 3);
    cycle(1'b1, 32'h0000_0000);
    idle(17);
    cycle(1'b1, 32'h0000_0009);
    idle(2 * FT);
    // disable written on the wrap cycle itself
    goto_wrap();
    cycle(1'b1, 32'h0000_0000);
    idle(3 * FT);
    cycle(1'b1, 32'hFFFF_FFF1);
    idle(2 * FT);
    // random config traffic
    for (int i = 0; i < 10 * FT; i++) begin
      if ($urandom_range(0, 199) == 0) cycle(1'b1, $urandom);
      else cycle(1'b0, $urandom);
    end
    // asynchronous reset in the middle of a line
    idle($urandom_range(5, 30));
    #2 rstn = 1'b0;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    rstn = 1'b1;
    cyc = 0; last_fs = 0;
    idle(2 * FT + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
